// File: rtl/layer_sequencer.sv
// Multi-stage layer sequencer: starts each compute stage, then streams (ch,row,col) transfer
// beats into the next stage. Optional perf_cycles counter when LAYER_SEQ_PERF_EN is defined.
module layer_sequencer #(
  parameter int unsigned                NUM_STAGES    = 3,
  parameter int unsigned                IDX_W         = 16,
  parameter logic [16*NUM_STAGES-1:0]   XFER_DIM_LIST = {16'd13, 16'd26, 16'd0},
  parameter logic [16*NUM_STAGES-1:0]   XFER_CH_LIST  = {16'd16, 16'd16, 16'd0}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  xfer_valid,
  input  logic                  xfer_ready,
  output logic [2:0]            xfer_stage,
  output logic [IDX_W-1:0]      xfer_col,
  output logic [IDX_W-1:0]      xfer_row,
  output logic [IDX_W-1:0]      xfer_ch,
  output logic                  busy,
  output logic                  done,
`ifdef LAYER_SEQ_PERF_EN
  output logic [31:0]           perf_cycles,
`endif
  output logic                  err
);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StXfer, StFin} state_e;

  localparam logic [IDX_W-1:0] IdxOne = 1;

  state_e           state_q, state_d;
  logic [2:0]       cur_q, cur_d;
  logic [IDX_W-1:0] col_q, col_d, row_q, row_d, ch_q, ch_d;
  logic             err_q, err_d;
  logic [31:0]      cur_ext;
  logic             cur_done, other_done;
  logic [15:0]      dim_f, ch_f;
  logic [IDX_W-1:0] dim_m1, ch_m1;

  assign cur_ext = 32'(cur_q);

  // Per-stage decode of the current stage: its done bit, its transfer shape and its start pulse.
  always_comb begin
    cur_done    = 1'b0;
    other_done  = 1'b0;
    dim_f       = '0;
    ch_f        = '0;
    stage_start = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (k == cur_ext) begin
        cur_done       = stage_done[k];
        dim_f          = XFER_DIM_LIST[16*k +: 16];
        ch_f           = XFER_CH_LIST[16*k +: 16];
        stage_start[k] = (state_q == StStart);
      end else if (stage_done[k]) begin
        other_done = 1'b1;
      end
    end
  end

  assign dim_m1 = IDX_W'(dim_f) - IdxOne;
  assign ch_m1  = IDX_W'(ch_f) - IdxOne;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    col_d   = col_q;
    row_d   = row_q;
    ch_d    = ch_q;
    err_d   = err_q | other_done;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_d   = '0;
          err_d   = other_done;
          state_d = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (cur_done) begin
          if (cur_ext == NUM_STAGES - 1) begin
            state_d = StFin;
          end else begin
            state_d = StXfer;
            cur_d   = cur_q + 3'd1;
            col_d   = '0;
            row_d   = '0;
            ch_d    = '0;
          end
        end
      end
      StXfer: begin
        if (xfer_ready) begin
          if (col_q != dim_m1) begin
            col_d = col_q + IdxOne;
          end else begin
            col_d = '0;
            if (row_q != dim_m1) begin
              row_d = row_q + IdxOne;
            end else begin
              row_d = '0;
              if (ch_q != ch_m1) begin
                ch_d = ch_q + IdxOne;
              end else begin
                ch_d    = '0;
                state_d = StStart;
              end
            end
          end
        end
      end
      StFin: begin
        state_d = StIdle;
        cur_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
  end

  assign xfer_valid = (state_q == StXfer);
  assign xfer_stage = cur_q;
  assign xfer_col   = col_q;
  assign xfer_row   = row_q;
  assign xfer_ch    = ch_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign err        = err_q;

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Counts every non-idle cycle of the run, saturating; held while idle until the next start.
  always_comb begin
    perf_d = perf_q;
    if (state_q == StIdle && start) begin
      perf_d = '0;
    end else if (busy && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
